// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// parity/majority helpers used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_START  = 6'b000010,
    ST_DATA   = 6'b000100,
    ST_PARITY = 6'b001000,
    ST_STOP   = 6'b010000,
    ST_BREAK  = 6'b100000
  } rx_state_e;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Line front end: 2-FF synchronizer, 3-sample history and the oversampling
// counter that marks the per-bit decision tick.
module uart_rx_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic serial_in,
  input  logic cnt_clr,
  output logic line_s,
  output logic bit_strobe,
  output logic bit_val
);

  localparam int              CW       = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]   CNT_DEC  = CW'(OVERSAMPLE / 2 + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [1:0]    hist_r;
  logic [CW-1:0] os_cnt_r;

  // synchronizer runs every clock; idle line level is high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= serial_in;
      sync2_r <= sync1_r;
    end
  end

  // sample history and oversampling counter advance only on ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_r   <= 2'b11;
      os_cnt_r <= '0;
    end else if (sample_en) begin
      hist_r <= {hist_r[0], sync2_r};
      if (cnt_clr) begin
        os_cnt_r <= '0;
      end else if (os_cnt_r == CNT_LAST) begin
        os_cnt_r <= '0;
      end else begin
        os_cnt_r <= os_cnt_r + CW'(1);
      end
    end else begin
      hist_r   <= hist_r;
      os_cnt_r <= os_cnt_r;
    end
  end

  // hist_r holds the MID-1 and MID samples when the counter reaches MID+1
  assign line_s     = sync2_r;
  assign bit_strobe = sample_en & (os_cnt_r == CNT_DEC);
  assign bit_val    = majority3(hist_r[1], hist_r[0], sync2_r);

endmodule

// File: rtl/uart_rx_sm.sv
// UART receiver: frames start/8 data/optional parity/stop from the sampled
// line and reports each byte with a one-clock data_valid pulse.
module uart_rx_sm
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 parity_bit,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 uart_state
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_e            state_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 par_en_r;
  logic                 par_rx_r;
  logic                 line_s;
  logic                 bit_strobe_s;
  logic                 bit_val_s;
  logic                 cnt_clr_s;

  assign cnt_clr_s = (state_r == ST_IDLE) & ~line_s;

  uart_rx_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .serial_in  (serial_in),
    .cnt_clr    (cnt_clr_s),
    .line_s     (line_s),
    .bit_strobe (bit_strobe_s),
    .bit_val    (bit_val_s)
  );

  // frame FSM with registered outputs; data_valid self-clears every clock
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      bit_idx_r  <= 3'd0;
      data_r     <= '0;
      par_en_r   <= 1'b0;
      par_rx_r   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (sample_en) begin
        case (state_r)
          ST_IDLE: begin
            if (!line_s) begin
              par_en_r   <= parity_bit;
              state_r    <= ST_START;
              uart_state <= 1'b1;
            end
          end
          ST_START: begin
            if (bit_strobe_s) begin
              if (bit_val_s) begin
                state_r    <= ST_IDLE;
                uart_state <= 1'b0;
              end else begin
                state_r   <= ST_DATA;
                bit_idx_r <= 3'd0;
              end
            end
          end
          ST_DATA: begin
            if (bit_strobe_s) begin
              data_r[bit_idx_r] <= bit_val_s;
              if (bit_idx_r == LAST_BIT) begin
                state_r <= par_en_r ? ST_PARITY : ST_STOP;
              end else begin
                bit_idx_r <= bit_idx_r + 3'd1;
              end
            end
          end
          ST_PARITY: begin
            if (bit_strobe_s) begin
              par_rx_r <= bit_val_s;
              state_r  <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (bit_strobe_s) begin
              data_out   <= data_r;
              frame_err  <= ~bit_val_s;
              parity_err <= par_en_r & (par_rx_r != parity_of(data_r));
              data_valid <= 1'b1;
              // leave half a bit early so a back-to-back start edge is seen
              if (bit_val_s) begin
                state_r    <= ST_IDLE;
                uart_state <= 1'b0;
              end else begin
                state_r <= ST_BREAK;
              end
            end
          end
          ST_BREAK: begin
            if (line_s) begin
              state_r    <= ST_IDLE;
              uart_state <= 1'b0;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            uart_state <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
